// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter. It carries the fetch port, the data port, the shared memory port and status.
// The slave modport is the arbiter side. The master modport is the requesters plus the memory.
interface mem_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_done;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_done;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    logic              busy;
    logic              err;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        output if_rdata, if_done, d_rdata, d_done, mem_en, mem_we, mem_addr, mem_wdata,
               busy, err
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        input  if_rdata, if_done, d_rdata, d_done, mem_en, mem_we, mem_addr, mem_wdata,
               busy, err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter that lets a fetch port and a data port share one memory port.
// It serves one access at a time and gives up on an access after TIMEOUT cycles without mem_ready.
module mem_arbiter #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           rst_n,
    mem_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t            state_q, state_d;
    logic              grant_data_q, grant_data_d;   // owner of the access in flight
    logic              last_grant_q, last_grant_d;   // 1 = data port was granted last
    logic [7:0]        wait_q, wait_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              if_done_q, if_done_d;
    logic              d_done_q, d_done_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              pick_data;

    // On a tie the port that was not served last wins.
    assign pick_data = bus.d_req && (!bus.if_req || !last_grant_q);

    always_comb begin
        state_d      = state_q;
        grant_data_d = grant_data_q;
        last_grant_d = last_grant_q;
        wait_d       = wait_q;
        mem_en_d     = mem_en_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        busy_d       = busy_q;
        if_done_d    = 1'b0;
        d_done_d     = 1'b0;
        err_d        = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.if_req || bus.d_req) begin
                    state_d      = ACCESS;
                    busy_d       = 1'b1;
                    mem_en_d     = 1'b1;
                    wait_d       = 8'd0;
                    grant_data_d = pick_data;
                    last_grant_d = pick_data;
                    if (pick_data) begin
                        mem_we_d    = bus.d_we;
                        mem_addr_d  = bus.d_addr;
                        mem_wdata_d = bus.d_wdata;
                    end else begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = bus.if_addr;
                        mem_wdata_d = '0;
                    end
                end
            end
            ACCESS: begin
                if (bus.mem_ready) begin
                    state_d  = RESP;
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    if (grant_data_q) begin
                        d_done_d = 1'b1;
                        if (!mem_we_q) d_rdata_d = bus.mem_rdata;
                    end else begin
                        if_done_d  = 1'b1;
                        if_rdata_d = bus.mem_rdata;
                    end
                end else if (wait_q == TIMEOUT_CNT) begin
                    // A timed-out access returns zero data and reports err with its done pulse.
                    state_d  = RESP;
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    err_d    = 1'b1;
                    if (grant_data_q) begin
                        d_done_d  = 1'b1;
                        d_rdata_d = '0;
                    end else begin
                        if_done_d  = 1'b1;
                        if_rdata_d = '0;
                    end
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_data_q <= 1'b0;
            last_grant_q <= 1'b1;
            wait_q       <= 8'd0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
            if_done_q    <= 1'b0;
            d_done_q     <= 1'b0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_data_q <= grant_data_d;
            last_grant_q <= last_grant_d;
            wait_q       <= wait_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
            if_done_q    <= if_done_d;
            d_done_q     <= d_done_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.if_done   = if_done_q;
    assign bus.d_done    = d_done_q;
    assign bus.err       = err_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests push their expected response, and a monitor checks every done pulse.
// A memory responder process inserts a chosen number of wait states and measures the strobe length of each access.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.DATA_W(32), .ADDR_W(32)) bus ();

    mem_arbiter #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic        is_d;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   wait_cycles = 0;
    logic stray_ready = 1'b0;
    int   en_len = 0;
    int   we_len = 0;
    logic [31:0] a0 = '0;
    logic [31:0] wd0 = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        case (addr)
            32'h10:  return 32'h2009_0000;
            32'h100: return 32'h1111_0100;
            32'h200: return 32'h2222_0200;
            default: return 32'hDEAD_0000 | {16'h0, addr[15:0]};
        endcase
    endfunction

    // Memory responder. It asserts mem_ready after wait_cycles stall cycles and checks that the bus stays stable.
    initial begin : responder
        int   cnt;
        logic rdy;
        cnt = 0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'hBAD0_BAD0;
        forever begin
            @(posedge clk);
            #2;
            if (bus.mem_en) begin
                cnt++;
                if (cnt == 1) begin
                    a0     = bus.mem_addr;
                    wd0    = bus.mem_wdata;
                    we_len = 32'(bus.mem_we);
                end else begin
                    check("access_addr_stable", bus.mem_addr, a0);
                    check("access_wdata_stable", bus.mem_wdata, wd0);
                    we_len = we_len + 32'(bus.mem_we);
                end
                en_len = cnt;
            end else begin
                cnt = 0;
            end
            rdy = bus.mem_en && (cnt > wait_cycles);
            bus.mem_ready = rdy | stray_ready;
            bus.mem_rdata = rdy ? mem_word(bus.mem_addr) : 32'hBAD0_BAD0;
        end
    end

    // Monitor: pop one expectation per done cycle.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.if_done && bus.d_done) begin
                n_cmp++;
                n_fail++;
                $display("FAIL both_done: got if_done=1 d_done=1, expected at most one");
            end else if (bus.if_done || bus.d_done) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_done: got if_done=%0b d_done=%0b, expected none", bus.if_done, bus.d_done);
                end else begin
                    e = sb.pop_front();
                    $display("done: port=%s rdata=0x%08h err=%0b", bus.d_done ? "data" : "fetch",
                             bus.d_done ? bus.d_rdata : bus.if_rdata, bus.err);
                    check("done_port", 32'(bus.d_done), 32'(e.is_d));
                    check("done_rdata", bus.d_done ? bus.d_rdata : bus.if_rdata, e.rdata);
                    check("done_err", 32'(bus.err), 32'(e.err));
                end
            end
        end
    end

    task automatic wait_done(input bit is_d);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (is_d ? bus.d_done : bus.if_done) seen = 1'b1;
        end
        if (!seen) begin
            n_cmp++;
            n_fail++;
            $display("FAIL done_wait: got no done within 40 cycles, expected done on %s port", is_d ? "data" : "fetch");
        end
    endtask

    task automatic access(input bit is_d, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          input int waitc, input logic [31:0] exp_rdata, input bit exp_err);
        wait_cycles = waitc;
        sb.push_back('{is_d, exp_rdata, exp_err});
        @(posedge clk);
        #1;
        if (is_d) begin
            d_we_set(we);
            bus.d_addr  = addr;
            bus.d_wdata = wdata;
            bus.d_req   = 1'b1;
        end else begin
            bus.if_addr = addr;
            bus.if_req  = 1'b1;
        end
        wait_done(is_d);
        @(posedge clk);
        #1;
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
    endtask

    task automatic d_we_set(input bit we);
        bus.d_we = we;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish by 200000, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int dones;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;

        // Values while reset is held.
        repeat (3) @(negedge clk);
        check("rst_mem_en_we", {30'h0, bus.mem_en, bus.mem_we}, 32'h0);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        check("rst_mem_wdata", bus.mem_wdata, 32'h0);
        check("rst_if_rdata", bus.if_rdata, 32'h0);
        check("rst_d_rdata", bus.d_rdata, 32'h0);
        check("rst_done_err_busy", {28'h0, bus.if_done, bus.d_done, bus.err, bus.busy}, 32'h0);

        // Contention from reset release: expected order is fetch, data, fetch, data.
        wait_cycles = 0;
        bus.if_addr = 32'h100;
        bus.d_addr  = 32'h200;
        bus.if_req  = 1'b1;
        bus.d_req   = 1'b1;
        sb.push_back('{1'b0, 32'h1111_0100, 1'b0});
        sb.push_back('{1'b1, 32'h2222_0200, 1'b0});
        sb.push_back('{1'b0, 32'h1111_0100, 1'b0});
        sb.push_back('{1'b1, 32'h2222_0200, 1'b0});
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 60 && dones < 4; i++) begin
            @(negedge clk);
            if (bus.if_done || bus.d_done) dones++;
        end
        check("contention_dones", 32'(dones), 32'd4);
        @(posedge clk);
        #1;
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;

        // Single fetch from 0x10 with zero wait states.
        access(1'b0, 1'b0, 32'h10, 32'h0, 0, 32'h2009_0000, 1'b0);
        check("fetch_addr", a0, 32'h10);
        check("fetch_we_cycles", 32'(we_len), 32'd0);

        // Store with two wait states. d_rdata must keep its previous load value.
        access(1'b1, 1'b1, 32'h8, 32'h28, 2, 32'h2222_0200, 1'b0);
        check("store_en_cycles", 32'(en_len), 32'd3);
        check("store_we_cycles", 32'(we_len), 32'd3);
        check("store_wdata", wd0, 32'h28);
        check("store_addr", a0, 32'h8);

        // Load that times out: strobe lasts TIMEOUT+1 cycles, returns zero data with err set.
        access(1'b1, 1'b0, 32'h44, 32'h0, 1000, 32'h0, 1'b1);
        check("timeout_en_cycles", 32'(en_len), 32'd5);
        access(1'b0, 1'b0, 32'h10, 32'h0, 0, 32'h2009_0000, 1'b0);

        // A stray mem_ready pulse while idle must not produce a done.
        @(posedge clk);
        #1;
        stray_ready = 1'b1;
        @(posedge clk);
        #1;
        stray_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("stray_no_done_busy", {29'h0, bus.if_done, bus.d_done, bus.busy}, 32'h0);

        // An if_addr change during ACCESS must not reach mem_addr.
        wait_cycles = 2;
        sb.push_back('{1'b0, 32'h1111_0100, 1'b0});
        @(posedge clk);
        #1;
        bus.if_addr = 32'h100;
        bus.if_req  = 1'b1;
        @(posedge clk);
        #1;
        bus.if_addr = 32'h300;
        @(negedge clk);
        check("addr_change_mem_addr", bus.mem_addr, 32'h100);
        wait_done(1'b0);
        @(posedge clk);
        #1;
        bus.if_req = 1'b0;

        // Asserting reset during ACCESS aborts the access immediately and produces no done.
        wait_cycles = 1000;
        @(posedge clk);
        #1;
        bus.if_addr = 32'h60;
        bus.if_req  = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        check("pre_reset_mem_en", 32'(bus.mem_en), 32'd1);
        rst_n = 1'b0;
        #1;
        check("reset_async_en_busy", {30'h0, bus.mem_en, bus.busy}, 32'h0);
        bus.if_req = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        access(1'b0, 1'b0, 32'h10, 32'h0, 0, 32'h2009_0000, 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
